pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameters: LOAD_BUBBLES, default 1, load-use bubble count (legal 1..3); MEM_TIMEOUT, default 255, mem_busy cycles before error (legal 1..65535); CNT_W, default 32, perf counter width.
REQ-002 SHALL have ports, in order: clk  in  1  single clock, all state updates on rising edge; rst  in  1  synchronous active-high reset.
REQ-003 mem_read_ex  in  1  EX-stage instruction is a load.
REQ-004 rd_ex  in  5  EX-stage destination register.
REQ-005 rs1_id, rs2_id  in  5 each  ID-stage source registers.
REQ-006 rs1_used_id, rs2_used_id  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 pc_src_ex  in  1  taken branch/jump redirect resolved in EX.
REQ-008 mem_busy  in  1  data memory not ready; the whole pipe must freeze.
REQ-009 md_start  in  1  multi-cycle mul/div entering EX; md_done  in  1  mul/div result valid.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage register enables, 1 = advance.
REQ-011 if_id_flush  out  1  zero IF/ID; id_ex_bubble  out  1  load NOP into ID/EX.
REQ-012 mem_timeout  out  1  sticky error flag; stall_cycles, flush_events  out  CNT_W each  perf counters.

Function
REQ-013 Load-use hazard (LU) SHALL be: mem_read_ex & rd_ex!=0 & ((rs1_used_id & rd_ex==rs1_id) | (rs2_used_id & rd_ex==rs2_id)).
REQ-014 FSM states SHALL be RUN, LOAD_STALL, MD_WAIT; reset state RUN.
REQ-015 Input priority each cycle SHALL be: mem_busy > pc_src_ex > LU > md_start.
REQ-016 mem_busy=1 in any state: all five write enables 0, if_id_flush=0, id_ex_bubble=0; state and bubble counter hold; stall_cycles increments.
REQ-017 RUN with pc_src_ex=1 (mem_busy=0): if_id_flush=1, id_ex_bubble=1, all write enables 1; flush_events increments; state stays RUN; a simultaneous LU or md_start is ignored.
REQ-018 RUN with LU: pc_write=0, if_id_write=0, id_ex_bubble=1, other enables 1; stall_cycles increments; if LOAD_BUBBLES>1, next state LOAD_STALL with counter loaded to LOAD_BUBBLES-1, else stay RUN.
REQ-019 LOAD_STALL: same outputs as REQ-018; counter decrements; counter==1 transitions to RUN next cycle; pc_src_ex ignored (EX holds a bubble).
REQ-020 RUN with md_start (no higher-priority event): go to MD_WAIT; this cycle outputs are normal advance.
REQ-021 MD_WAIT: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=0, ex_mem_write=1 with EX/MEM loaded with a bubble (mem_wb_write=1); stall_cycles increments; md_done=1 returns to RUN in the same cycle with normal advance outputs.
REQ-022 md_done outside MD_WAIT SHALL be ignored.
REQ-023 A busy counter SHALL count consecutive mem_busy=1 cycles, clear when mem_busy=0, and saturate; when it reaches MEM_TIMEOUT, mem_timeout SHALL set and remain 1 until rst.
REQ-024 Perf counters SHALL wrap modulo 2^CNT_W; at most one increment per counter per cycle.
REQ-025 Write-enable outputs, if_id_flush and id_ex_bubble SHALL be combinational from state and inputs; no added latency.

Reset
REQ-026 rst=1 at a rising edge SHALL force state RUN, bubble and busy counters 0, mem_timeout 0, stall_cycles 0, flush_events 0, regardless of other inputs, including mid-LOAD_STALL, mid-MD_WAIT or mid-mem_busy.
REQ-027 While rst=1, all write enables SHALL be 0, if_id_flush=1, id_ex_bubble=1.

Verification
REQ-028 LOAD_BUBBLES=1, mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 exactly 1 cycle; stall_cycles=1.
REQ-029 LOAD_BUBBLES=3, same stimulus -> stall outputs for 3 consecutive cycles, then RUN; stall_cycles=3; rd_ex=0 variant -> no stall.
REQ-030 pc_src_ex=1 together with LU -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall; flush_events=1.
REQ-031 md_start, then md_done after 4 cycles in MD_WAIT -> front end frozen 4 cycles, advance on md_done cycle; stall_cycles=4.
REQ-032 MEM_TIMEOUT=4, mem_busy=1 for 6 cycles during LOAD_STALL -> all enables 0 for 6 cycles, counter frozen, mem_timeout=1 from 4th busy cycle and sticky; stall resumes after mem_busy drops.
REQ-033 rst=1 asserted in MD_WAIT with stall_cycles=7 -> next cycle state RUN, all counters 0, mem_timeout 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - in-order pipeline stall/flush controller with memory timeout and perf counters
module pipeline_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             pc_src_ex,
    input  logic             mem_busy,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0]  LB_INIT  = 2'(LOAD_BUBBLES - 1);
    localparam logic [15:0] BUSY_MAX = 16'(MEM_TIMEOUT);
    localparam logic [16:0] BUSY_LIM = 17'(MEM_TIMEOUT);

    state_t      state;
    logic [1:0]  bub_cnt;
    logic [15:0] busy_cnt;
    logic        load_use;
    logic        stall_inc;
    logic        flush_inc;

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rd_ex == rs1_id)) ||
                       (rs2_used_id && (rd_ex == rs2_id)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            stall_inc    = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (pc_src_ex) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_inc    = 1'b1;
                end
                MD_WAIT: begin
                    // EX keeps the mul/div op; EX/MEM takes a bubble meanwhile
                    if (!md_done) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        stall_inc   = 1'b1;
                    end
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            bub_cnt      <= 2'd0;
            busy_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc) begin
                flush_events <= flush_events + CNT_W'(1);
            end
            if (mem_busy) begin
                if (busy_cnt != BUSY_MAX) begin
                    busy_cnt <= busy_cnt + 16'd1;
                end
                if (({1'b0, busy_cnt} + 17'd1) >= BUSY_LIM) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                busy_cnt <= 16'd0;
                case (state)
                    RUN: begin
                        if (!pc_src_ex && load_use) begin
                            if (LOAD_BUBBLES > 1) begin
                                state   <= LOAD_STALL;
                                bub_cnt <= LB_INIT;
                            end
                        end else if (!pc_src_ex && md_start) begin
                            state <= MD_WAIT;
                        end
                    end
                    LOAD_STALL: begin
                        bub_cnt <= bub_cnt - 2'd1;
                        if (bub_cnt <= 2'd1) begin
                            state <= RUN;
                        end
                    end
                    MD_WAIT: begin
                        if (md_done) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - two-configuration hazard controller bench against a cycle-level reference model
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_read_ex, rs1_used_id, rs2_used_id, pc_src_ex, mem_busy, md_start, md_done;
    logic [4:0] rd_ex, rs1_id, rs2_id;

    logic       pcw_a, ifw_a, idw_a, exw_a, mww_a, fl_a, bb_a, tmo_a;
    logic       pcw_b, ifw_b, idw_b, exw_b, mww_b, fl_b, bb_b, tmo_b;
    logic [7:0] stall_a, flush_a, stall_b, flush_b;
    logic [6:0] out_a, out_b;

    assign out_a = {pcw_a, ifw_a, idw_a, exw_a, mww_a, fl_a, bb_a};
    assign out_b = {pcw_b, ifw_b, idw_b, exw_b, mww_b, fl_b, bb_b};

    pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(6), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .pc_src_ex(pc_src_ex), .mem_busy(mem_busy), .md_start(md_start), .md_done(md_done),
        .pc_write(pcw_a), .if_id_write(ifw_a), .id_ex_write(idw_a), .ex_mem_write(exw_a),
        .mem_wb_write(mww_a), .if_id_flush(fl_a), .id_ex_bubble(bb_a), .mem_timeout(tmo_a),
        .stall_cycles(stall_a), .flush_events(flush_a)
    );

    pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .pc_src_ex(pc_src_ex), .mem_busy(mem_busy), .md_start(md_start), .md_done(md_done),
        .pc_write(pcw_b), .if_id_write(ifw_b), .id_ex_write(idw_b), .ex_mem_write(exw_b),
        .mem_wb_write(mww_b), .if_id_flush(fl_b), .id_ex_bubble(bb_b), .mem_timeout(tmo_b),
        .stall_cycles(stall_b), .flush_events(flush_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: remaining extra load bubbles, mul/div-in-flight flag, busy run length
    int lb [2] = '{1, 3};
    int mt [2] = '{6, 4};
    int m_load [2], m_busy [2], m_stall [2], m_flush [2];
    bit m_md [2], m_tmo [2];
    int n_load [2], n_busy [2], n_stall [2], n_flush [2];
    bit n_md [2], n_tmo [2];

    localparam logic [6:0] O_RST   = 7'b0000011;
    localparam logic [6:0] O_FRZ   = 7'b0000000;
    localparam logic [6:0] O_ADV   = 7'b1111100;
    localparam logic [6:0] O_LOAD  = 7'b0011101;
    localparam logic [6:0] O_FLUSH = 7'b1111111;
    localparam logic [6:0] O_MD    = 7'b0001100;

    task automatic model_eval(input int i, output logic [6:0] o);
        bit lu;
        lu = mem_read_ex && rd_ex != 0 &&
             ((rs1_used_id && rd_ex == rs1_id) || (rs2_used_id && rd_ex == rs2_id));
        n_load[i] = m_load[i]; n_busy[i] = m_busy[i]; n_stall[i] = m_stall[i];
        n_flush[i] = m_flush[i]; n_md[i] = m_md[i]; n_tmo[i] = m_tmo[i];
        if (rst) begin
            o = O_RST;
            n_load[i] = 0; n_busy[i] = 0; n_stall[i] = 0; n_flush[i] = 0;
            n_md[i] = 0; n_tmo[i] = 0;
        end else if (mem_busy) begin
            o = O_FRZ;
            n_stall[i]++;
            n_busy[i] = (m_busy[i] + 1 > mt[i]) ? mt[i] : m_busy[i] + 1;
            if (n_busy[i] >= mt[i]) n_tmo[i] = 1;
        end else begin
            n_busy[i] = 0;
            if (m_md[i]) begin
                if (md_done) begin o = O_ADV; n_md[i] = 0; end
                else begin o = O_MD; n_stall[i]++; end
            end else if (m_load[i] > 0) begin
                o = O_LOAD; n_stall[i]++; n_load[i]--;
            end else if (pc_src_ex) begin
                o = O_FLUSH; n_flush[i]++;
            end else if (lu) begin
                o = O_LOAD; n_stall[i]++; n_load[i] = lb[i] - 1;
            end else if (md_start) begin
                o = O_ADV; n_md[i] = 1;
            end else begin
                o = O_ADV;
            end
        end
        n_stall[i] = n_stall[i] % 256;
        n_flush[i] = n_flush[i] % 256;
    endtask

    task automatic cycle();
        logic [6:0] ea, eb;
        model_eval(0, ea);
        model_eval(1, eb);
        #2;
        check("outs_a", 32'(out_a), 32'(ea));
        check("outs_b", 32'(out_b), 32'(eb));
        check("stall_a", 32'(stall_a), m_stall[0]);
        check("stall_b", 32'(stall_b), m_stall[1]);
        check("flush_a", 32'(flush_a), m_flush[0]);
        check("flush_b", 32'(flush_b), m_flush[1]);
        check("tmo_a", 32'(tmo_a), 32'(m_tmo[0]));
        check("tmo_b", 32'(tmo_b), 32'(m_tmo[1]));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_load[i] = n_load[i]; m_busy[i] = n_busy[i]; m_stall[i] = n_stall[i];
            m_flush[i] = n_flush[i]; m_md[i] = n_md[i]; m_tmo[i] = n_tmo[i];
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        mem_read_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        pc_src_ex = 0; mem_busy = 0; md_start = 0; md_done = 0;
    endtask

    task automatic set_lu();
        set_idle();
        mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_load[i] = 0; m_busy[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_md[i] = 0; m_tmo[i] = 0;
        end
        cycle();
        check("rst_outs_a", 32'(out_a), 32'(O_RST));
        rst = 0;

        // single load-use: one bubble vs three bubbles
        set_lu(); cycle();
        set_idle(); repeat (4) cycle();
        check("lu1_stall", 32'(stall_a), 1);
        check("lu3_stall", 32'(stall_b), 3);

        do_reset();
        set_lu(); rd_ex = 0; cycle();
        set_idle(); repeat (3) cycle();
        check("rd0_stall_a", 32'(stall_a), 0);
        check("rd0_stall_b", 32'(stall_b), 0);

        // redirect wins over load-use
        do_reset();
        set_lu(); pc_src_ex = 1; cycle();
        set_idle(); cycle();
        check("redir_flush", 32'(flush_a), 1);
        check("redir_stall", 32'(stall_b), 0);

        // mul/div: four wait cycles then done
        do_reset();
        md_start = 1; cycle();
        set_idle(); repeat (4) cycle();
        md_done = 1; cycle();
        set_idle(); cycle();
        check("md_stall_a", 32'(stall_a), 4);
        check("md_stall_b", 32'(stall_b), 4);

        // memory busy during a load stall, long enough to trip the timeout
        do_reset();
        set_lu(); cycle();
        set_idle(); mem_busy = 1; repeat (6) cycle();
        mem_busy = 0; repeat (3) cycle();
        check("busy_stall_b", 32'(stall_b), 9);
        check("busy_stall_a", 32'(stall_a), 7);
        check("busy_tmo_b", 32'(tmo_b), 1);
        check("busy_tmo_a", 32'(tmo_a), 1);

        // reset in the middle of a mul/div wait
        do_reset();
        md_start = 1; cycle();
        set_idle(); repeat (7) cycle();
        check("md7_stall", 32'(stall_a), 7);
        rst = 1; cycle();
        rst = 0; cycle();
        check("md_rst_stall", 32'(stall_a), 0);

        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            mem_read_ex = ($urandom_range(0, 9) < 4);
            rd_ex       = 5'($urandom_range(0, 3));
            rs1_id      = 5'($urandom_range(0, 3));
            rs2_id      = 5'($urandom_range(0, 3));
            rs1_used_id = $urandom_range(0, 1) == 1;
            rs2_used_id = $urandom_range(0, 1) == 1;
            pc_src_ex   = ($urandom_range(0, 9) == 0);
            mem_busy    = ($urandom_range(0, 9) == 0) || (mem_busy && $urandom_range(0, 9) < 7);
            md_start    = ($urandom_range(0, 19) < 3);
            md_done     = ($urandom_range(0, 9) < 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
